rf_dump_streamer: RTL and testbench

Debug unload engine that sits downstream of the core's register file. On a start pulse it halts the core, reads x0..x(NUM_REGS-1) through a dedicated asynchronous read port, and streams each {index, value} pair out over a valid/ready interface. This gives the simulation harness and later an on-chip debug link a hardware register dump, replacing hierarchical peeking into the register array.

---
 rtl/rf_dump_streamer.sv | 122 ++++++++++++
 tb/tb_rf_dump_streamer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_streamer.sv
// rtl/rf_dump_streamer.sv - halts the core and streams every register file entry as {index, value} words
module rf_dump_streamer #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int IDX_W    = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_halt_req,
    input  logic             i_halt_ack,
    output logic [IDX_W-1:0] o_rd_addr,
    input  logic [XLEN-1:0]  i_rd_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [IDX_W-1:0] o_out_idx,
    output logic [XLEN-1:0]  o_out_data,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HALT,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_out_idx;
    logic [XLEN-1:0]  r_out_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (i_start) w_next_state = S_WAIT_HALT;
            S_WAIT_HALT: if (i_halt_ack) w_next_state = S_READ;
            S_READ:      w_next_state = S_SEND;
            S_SEND:      if (i_out_ready) w_next_state = (r_idx == LAST_IDX) ? S_DONE : S_READ;
            S_DONE:      w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
        // abort outranks every other transition but is meaningless in IDLE
        if (i_abort && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx      <= '0;
            r_out_idx  <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) r_idx <= '0;
                end
                S_READ: begin
                    if (!i_abort) begin
                        r_out_idx  <= r_idx;
                        r_out_data <= i_rd_data;
                    end
                end
                S_SEND: begin
                    if (!i_abort && i_out_ready && (r_idx != LAST_IDX)) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_halt_req  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_rd_addr   = '0;
        case (r_state)
            S_WAIT_HALT: begin
                o_halt_req = 1'b1;
                o_busy     = 1'b1;
            end
            S_READ: begin
                o_halt_req = 1'b1;
                o_busy     = 1'b1;
                o_rd_addr  = r_idx;
            end
            S_SEND: begin
                o_halt_req  = 1'b1;
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                o_rd_addr   = r_idx;
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_out_idx  = r_out_idx;
    assign o_out_data = r_out_data;

endmodule

// File: tb/tb_rf_dump_streamer.sv
// tb/tb_rf_dump_streamer.sv - randomized directed bench for rf_dump_streamer against a cycle-timeline model
module tb_rf_dump_streamer;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        halt_ack = 1'b0;
    logic        out_ready = 1'b0;
    logic        halt_req;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic [4:0]  rd_addr;
    logic [4:0]  out_idx;
    logic [31:0] rd_data;
    logic [31:0] out_data;
    logic [31:0] rf [32];

    int vec_cnt = 0;
    int err_cnt = 0;

    bit ack_sched [N];
    bit rdy_sched [N];
    bit exp_valid [N];
    bit exp_busy  [N];
    bit exp_halt  [N];
    bit exp_done  [N];
    int exp_idx   [N];
    int exp_rdaddr[N];
    int send_start[32];
    int done_c;

    rf_dump_streamer #(.NUM_REGS(32), .XLEN(32), .IDX_W(5)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_abort    (abort),
        .o_halt_req (halt_req),
        .i_halt_ack (halt_ack),
        .o_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_idx  (out_idx),
        .o_out_data (out_data),
        .o_busy     (busy),
        .o_done     (done)
    );

    assign rd_data = rf[rd_addr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Timeline of the dump: WAIT_HALT from cycle 1 until ack, then one read cycle
    // and a send window per word that lasts until the sink's first ready cycle.
    function automatic void build_model(input int abort_cyc);
        int a;
        int r;
        int s;
        for (int c = 0; c < N; c++) begin
            exp_valid[c] = 0; exp_busy[c] = 0; exp_halt[c] = 0; exp_done[c] = 0;
            exp_idx[c] = 0; exp_rdaddr[c] = 0;
        end
        a = 1;
        while (a < N - 8 && !ack_sched[a]) a++;
        r = a + 1;
        for (int i = 0; i < 32; i++) begin
            exp_rdaddr[r] = i;
            s = r + 1;
            send_start[i] = s;
            while (s < N - 4 && !rdy_sched[s]) begin
                exp_valid[s] = 1; exp_idx[s] = i; exp_rdaddr[s] = i;
                s++;
            end
            exp_valid[s] = 1; exp_idx[s] = i; exp_rdaddr[s] = i;
            r = s + 1;
        end
        done_c = r;
        for (int c = 1; c <= done_c && c < N; c++) begin
            exp_busy[c] = 1;
            exp_halt[c] = (c < done_c);
        end
        exp_done[done_c] = 1;
        if (abort_cyc >= 0) begin
            for (int c = abort_cyc + 1; c < N; c++) begin
                exp_valid[c] = 0; exp_busy[c] = 0; exp_halt[c] = 0; exp_done[c] = 0;
                exp_rdaddr[c] = 0;
            end
        end
    endfunction

    task automatic check_cycle(input int c);
        chk("out_valid", 64'(out_valid), 64'(exp_valid[c]));
        chk("busy", 64'(busy), 64'(exp_busy[c]));
        chk("halt_req", 64'(halt_req), 64'(exp_halt[c]));
        chk("done", 64'(done), 64'(exp_done[c]));
        chk("rd_addr", 64'(rd_addr), 64'(exp_rdaddr[c]));
        if (exp_valid[c]) begin
            chk("out_idx", 64'(out_idx), 64'(exp_idx[c]));
            chk("out_data", 64'(out_data), 64'(rf[exp_idx[c]]));
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_halt_req", 64'(halt_req), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
    endtask

    // rdy_mode: 0 always ready, 1 toggling, 2 random (mostly ready)
    task automatic run_dump(input int ack_low, input int rdy_mode, input bit abort_at_15,
                            input bit rst_at_7, input bit start_at_4, input bit abort_with_start);
        int abort_cyc;
        int rst_cyc;
        int start_cyc;
        int last;
        abort_cyc = -1;
        rst_cyc = -1;
        start_cyc = -1;
        for (int c = 0; c < N; c++) begin
            if (c <= ack_low) ack_sched[c] = 0;
            else if (c == ack_low + 1) ack_sched[c] = 1;
            else ack_sched[c] = 1'($urandom_range(0, 1));
            case (rdy_mode)
                0:       rdy_sched[c] = 1;
                1:       rdy_sched[c] = 1'(c % 2);
                default: rdy_sched[c] = ($urandom_range(0, 3) != 0);
            endcase
        end
        build_model(-1);
        if (abort_at_15) begin
            abort_cyc = send_start[15];
            rdy_sched[abort_cyc] = 0;
            build_model(abort_cyc);
        end
        if (rst_at_7) rst_cyc = send_start[7];
        if (start_at_4) start_cyc = send_start[4];
        if (rst_cyc >= 0) last = rst_cyc;
        else if (abort_cyc >= 0) last = abort_cyc + 3;
        else last = done_c + 2;
        for (int c = 0; c <= last && c < N; c++) begin
            @(posedge clk);
            #1;
            check_cycle(c);
            start     = (c == 0) || (c == start_cyc);
            abort     = (c == abort_cyc) || (abort_with_start && c == 0);
            halt_ack  = ack_sched[c];
            out_ready = rdy_sched[c];
            if (c == rst_cyc) begin
                #3 rst_n = 1'b0;
                #1 check_reset_outputs();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        halt_ack = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic randomize_rf();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3 + 100);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        run_dump(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        randomize_rf();
        run_dump(0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        randomize_rf();
        run_dump(10, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        randomize_rf();
        run_dump(int'($urandom_range(0, 4)), 2, 1'b1, 1'b0, 1'b0, 1'b0);
        randomize_rf();
        run_dump(0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        randomize_rf();
        run_dump(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        randomize_rf();
        run_dump(int'($urandom_range(0, 3)), 2, 1'b0, 1'b0, 1'b0, 1'b1);
        randomize_rf();
        run_dump(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        randomize_rf();
        run_dump(int'($urandom_range(0, 5)), 2, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
